// File: rtl/fetch_decode_stage.sv
// Fetch/decode front end: drives the instruction-memory address from the PC,
// decodes the returned word into pipeline controls and registers the result
// toward the stage-1 buffer. Handles stall, taken-branch redirect, undefined
// opcodes and a terminal HALTED state that only reset can leave.
module fetch_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instruction,
    output logic [15:0] pc_out,
    output logic        valid_out,
    output logic [1:0]  branchOps1,
    output logic [3:0]  aluOps1,
    output logic        mux3sels1,
    output logic        r0Writes1,
    output logic        regWrites1,
    output logic        wEnables1,
    output logic        illegal,
    output logic        halted
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_MUL  = 4'h5;
    localparam logic [3:0] OP_DIV  = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BLT  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Architectural state
    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;

    // Registered outputs toward the stage-1 buffer
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [1:0]  branch_ops_q, branch_ops_d;
    logic [3:0]  alu_ops_q, alu_ops_d;
    logic        mux3_sel_q, mux3_sel_d;
    logic        r0_write_q, r0_write_d;
    logic        reg_write_q, reg_write_d;
    logic        w_enable_q, w_enable_d;
    logic        illegal_q, illegal_d;
    logic        halted_q, halted_d;

    // Decoded controls for the word currently on imem_data
    logic [3:0]  opcode;
    logic [1:0]  dec_branch_ops;
    logic [3:0]  dec_alu_ops;
    logic        dec_mux3_sel;
    logic        dec_r0_write;
    logic        dec_reg_write;
    logic        dec_w_enable;
    logic        dec_illegal;
    logic        dec_halt;

    assign opcode    = imem_data[15:12];
    assign imem_addr = pc_q;

    // Combinational opcode decode; anything not set for an opcode stays zero
    always_comb begin
        dec_branch_ops = 2'b00;
        dec_alu_ops    = 4'b0000;
        dec_mux3_sel   = 1'b0;
        dec_r0_write   = 1'b0;
        dec_reg_write  = 1'b0;
        dec_w_enable   = 1'b0;
        dec_illegal    = 1'b0;
        dec_halt       = 1'b0;
        case (opcode)
            OP_NOP: begin
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec_alu_ops   = opcode;
                dec_reg_write = 1'b1;
            end
            OP_MUL, OP_DIV: begin
                dec_alu_ops   = opcode;
                dec_reg_write = 1'b1;
                dec_r0_write  = 1'b1;
            end
            OP_LW: begin
                dec_alu_ops   = 4'b0001;
                dec_mux3_sel  = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_SW: begin
                dec_alu_ops  = 4'b0001;
                dec_w_enable = 1'b1;
            end
            OP_BEQ: begin
                dec_branch_ops = 2'b01;
                dec_alu_ops    = 4'b0010;
            end
            OP_BLT: begin
                dec_branch_ops = 2'b10;
                dec_alu_ops    = 4'b0010;
            end
            OP_JMP: begin
                dec_branch_ops = 2'b11;
            end
            OP_HALT: begin
                dec_halt = 1'b1;
            end
            default: begin
                // 0x7, 0xD, 0xE: pass through as a do-nothing instruction and flag it
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Next-state selection: redirect beats stall beats normal issue; HALTED only emits bubbles
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        branch_ops_d = branch_ops_q;
        alu_ops_d    = alu_ops_q;
        mux3_sel_d   = mux3_sel_q;
        r0_write_d   = r0_write_q;
        reg_write_d  = reg_write_q;
        w_enable_d   = w_enable_q;
        illegal_d    = illegal_q;

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    // Word fetched this cycle is on the wrong path, so squash it
                    pc_d         = redirect_pc;
                    instr_d      = 16'h0000;
                    valid_d      = 1'b0;
                    branch_ops_d = 2'b00;
                    alu_ops_d    = 4'b0000;
                    mux3_sel_d   = 1'b0;
                    r0_write_d   = 1'b0;
                    reg_write_d  = 1'b0;
                    w_enable_d   = 1'b0;
                    illegal_d    = 1'b0;
                end else if (!stall) begin
                    if (dec_halt) begin
                        // HALT leaves the PC on itself and becomes a bubble
                        state_d      = ST_HALTED;
                        instr_d      = 16'h0000;
                        valid_d      = 1'b0;
                        branch_ops_d = 2'b00;
                        alu_ops_d    = 4'b0000;
                        mux3_sel_d   = 1'b0;
                        r0_write_d   = 1'b0;
                        reg_write_d  = 1'b0;
                        w_enable_d   = 1'b0;
                        illegal_d    = 1'b0;
                    end else begin
                        pc_d         = pc_q + 16'd1;
                        instr_d      = imem_data;
                        pc_out_d     = pc_q;
                        valid_d      = 1'b1;
                        branch_ops_d = dec_branch_ops;
                        alu_ops_d    = dec_alu_ops;
                        mux3_sel_d   = dec_mux3_sel;
                        r0_write_d   = dec_r0_write;
                        reg_write_d  = dec_reg_write;
                        w_enable_d   = dec_w_enable;
                        illegal_d    = dec_illegal;
                    end
                end
            end
            default: begin
                // HALTED: frozen PC, bubble every cycle, redirect and stall ignored
                instr_d      = 16'h0000;
                valid_d      = 1'b0;
                branch_ops_d = 2'b00;
                alu_ops_d    = 4'b0000;
                mux3_sel_d   = 1'b0;
                r0_write_d   = 1'b0;
                reg_write_d  = 1'b0;
                w_enable_d   = 1'b0;
                illegal_d    = 1'b0;
            end
        endcase

        halted_d = (state_d == ST_HALTED);
    end

    // State and output registers with asynchronous active-low reset to a bubble at PC 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pc_q         <= 16'h0000;
            instr_q      <= 16'h0000;
            pc_out_q     <= 16'h0000;
            valid_q      <= 1'b0;
            branch_ops_q <= 2'b00;
            alu_ops_q    <= 4'b0000;
            mux3_sel_q   <= 1'b0;
            r0_write_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            w_enable_q   <= 1'b0;
            illegal_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            branch_ops_q <= branch_ops_d;
            alu_ops_q    <= alu_ops_d;
            mux3_sel_q   <= mux3_sel_d;
            r0_write_q   <= r0_write_d;
            reg_write_q  <= reg_write_d;
            w_enable_q   <= w_enable_d;
            illegal_q    <= illegal_d;
            halted_q     <= halted_d;
        end
    end

    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign valid_out   = valid_q;
    assign branchOps1  = branch_ops_q;
    assign aluOps1     = alu_ops_q;
    assign mux3sels1   = mux3_sel_q;
    assign r0Writes1   = r0_write_q;
    assign regWrites1  = reg_write_q;
    assign wEnables1   = w_enable_q;
    assign illegal     = illegal_q;
    assign halted      = halted_q;

endmodule
